// File: rtl/pipe_ctrl.sv
// Y86 five-stage pipeline control: hazard stall/bubble decoding, run-state
// sequencing (post-reset flush, freeze on terminal status) and hazard counters.
module pipe_ctrl #(
  parameter int          CNT_W = 32,
  parameter logic [2:0]  AOK   = 3'd1,
  parameter logic [2:0]  HLT   = 3'd2,
  parameter logic [2:0]  ADR   = 3'd3,
  parameter logic [2:0]  INS   = 3'd4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] cnt_cycles,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic [CNT_W-1:0] cnt_ret
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t state_r;
  logic   lu_s, rt_s, mp_s, m_exc_s, w_exc_s;

  function automatic logic exc(input logic [2:0] s);
    return (s == HLT) || (s == ADR) || (s == INS);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Hazard detection terms
  always_comb begin
    lu_s    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt_s    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp_s    = (E_icode == I_JXX) && !e_Cnd;
    m_exc_s = exc(m_stat);
    w_exc_s = exc(W_stat);
  end

  // Pipeline register control decoding by run state
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    case (state_r)
      ST_RUN: begin
        F_stall  = lu_s || rt_s;
        D_stall  = lu_s;
        D_bubble = mp_s || (!lu_s && rt_s);
        E_bubble = mp_s || lu_s;
        M_bubble = m_exc_s || w_exc_s;
        W_stall  = w_exc_s;
        set_cc   = (E_icode == I_OPQ) && !m_exc_s && !w_exc_s;
      end
      ST_FROZEN: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: begin
        // INIT (and any illegal encoding) flushes the pipe with bubbles
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
    endcase
  end

  // Run-state machine with latched terminal status
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= ST_INIT;
      halted     <= 1'b0;
      final_stat <= AOK;
    end else begin
      case (state_r)
        ST_INIT: state_r <= ST_RUN;
        ST_RUN: begin
          if (w_exc_s) begin
            state_r    <= ST_FROZEN;
            halted     <= 1'b1;
            final_stat <= W_stat;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FROZEN: state_r <= ST_FROZEN;
        default:   state_r <= ST_INIT;
      endcase
    end
  end

  // Saturating performance counters, active only while running
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_cycles  <= {CNT_W{1'b0}};
      cnt_loaduse <= {CNT_W{1'b0}};
      cnt_mispred <= {CNT_W{1'b0}};
      cnt_ret     <= {CNT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      cnt_cycles <= sat_inc(cnt_cycles);
      if (lu_s)          cnt_loaduse <= sat_inc(cnt_loaduse);
      if (mp_s)          cnt_mispred <= sat_inc(cnt_mispred);
      if (!lu_s && rt_s) cnt_ret     <= sat_inc(cnt_ret);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios then random traffic,
// checked against a rule-level reference model.
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic [3:0]       D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [3:0]       E_icode = 4'h1, E_dstM = 4'hF, M_icode = 4'h1;
  logic             e_Cnd = 1'b1;
  logic [2:0]       m_stat = 3'd1, W_stat = 3'd1;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic             halted;
  logic [2:0]       final_stat;
  logic [CNT_W-1:0] cnt_cycles, cnt_loaduse, cnt_mispred, cnt_ret;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
    .halted(halted), .final_stat(final_stat),
    .cnt_cycles(cnt_cycles), .cnt_loaduse(cnt_loaduse),
    .cnt_mispred(cnt_mispred), .cnt_ret(cnt_ret)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] ctl;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
    logic       halted;
    logic [2:0] fstat;
    int         c[4];
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: "init", "run" or "frozen" phase of the machine
  int       mode = 0;
  logic     m_halted = 1'b0;
  logic [2:0] m_fstat = 3'd1;
  int       m_cnt[4] = '{0, 0, 0, 0};

  function automatic bit is_exc(input logic [2:0] s);
    return s == 3'd2 || s == 3'd3 || s == 3'd4;
  endfunction

  task automatic cycle(input bit rst_low, input logic [3:0] di, sa, sb, ei, edm,
                       input logic cnd, input logic [3:0] mi, input logic [2:0] ms, ws);
    exp_t e;
    bit lu, rt, mp;
    @(posedge CLK);
    #1;
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = edm;
    e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
    RSTn = !rst_low;
    if (rst_low) begin
      mode = 0; m_halted = 1'b0; m_fstat = 3'd1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    lu = (ei == 4'h5 || ei == 4'hB) && edm != 4'hF && (edm == sa || edm == sb);
    rt = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
    mp = (ei == 4'h7) && !cnd;
    if (mode == 0)      e.ctl = 7'b0011100;
    else if (mode == 2) e.ctl = 7'b1100110;
    else e.ctl = {lu || rt, lu, mp || (!lu && rt), mp || lu,
                  is_exc(ms) || is_exc(ws), is_exc(ws),
                  ei == 4'h6 && !is_exc(ms) && !is_exc(ws)};
    e.halted = m_halted;
    e.fstat  = m_fstat;
    for (int i = 0; i < 4; i++) e.c[i] = m_cnt[i];
    sb_q.push_back(e);
    // advance the model across the coming clock edge
    if (!rst_low) begin
      if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (m_cnt[0] < MAXV) m_cnt[0]++;
        if (lu && m_cnt[1] < MAXV) m_cnt[1]++;
        if (mp && m_cnt[2] < MAXV) m_cnt[2]++;
        if (!lu && rt && m_cnt[3] < MAXV) m_cnt[3]++;
        if (is_exc(ws)) begin
          mode = 2; m_halted = 1'b1; m_fstat = ws;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
  endtask

  task automatic rst_pulse();
    cycle(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
  endtask

  // Scoreboard monitor: one expected record per cycle, sampled mid-cycle
  exp_t mon_e;
  int   act_c[4];
  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      act_c[0] = cnt_cycles; act_c[1] = cnt_loaduse;
      act_c[2] = cnt_mispred; act_c[3] = cnt_ret;
      n_tests++;
      if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} !== mon_e.ctl) begin
        n_fail++;
        $display("FAIL ctl t=%0t actual=%b required=%b", $time,
                 {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, mon_e.ctl);
      end
      n_tests++;
      if (halted !== mon_e.halted || final_stat !== mon_e.fstat) begin
        n_fail++;
        $display("FAIL status t=%0t actual=%b/%0d required=%b/%0d", $time,
                 halted, final_stat, mon_e.halted, mon_e.fstat);
      end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (act_c[i] !== mon_e.c[i]) begin
          n_fail++;
          $display("FAIL cnt%0d t=%0t actual=%0d required=%0d", i, $time, act_c[i], mon_e.c[i]);
        end
      end
    end
  end

  initial begin
    logic [3:0] ic_tab[8];
    logic [3:0] r_tab[5];
    logic [2:0] st_tab[6];
    ic_tab = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h0, 4'h2};
    r_tab  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
    st_tab = '{3'd1, 3'd1, 3'd0, 3'd3, 3'd4, 3'd2};

    // reset, INIT flush cycle, then running
    rst_pulse(); rst_pulse();
    idle(2);
    // load/use, then same load with no destination
    cycle(1'b0, 4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1);
    cycle(1'b0, 4'h6, 4'h3, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    // ret walking through D, E, M
    cycle(1'b0, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    cycle(1'b0, 4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
    cycle(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1);
    // mispredict, then OPq with a faulting memory stage
    cycle(1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
    cycle(1'b0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
    // load/use with ret, mispredict with ret
    cycle(1'b0, 4'h9, 4'h2, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 3'd1, 3'd1);
    cycle(1'b0, 4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
    // halt reaches writeback together with a hazard, then frozen
    cycle(1'b0, 4'h6, 4'h1, 4'hF, 4'h5, 4'h1, 1'b1, 4'h1, 3'd1, 3'd2);
    cycle(1'b0, 4'h9, 4'h1, 4'hF, 4'h7, 4'h1, 1'b0, 4'h9, 3'd3, 3'd1);
    idle(3);
    // asynchronous reset mid-freeze, then run into counter saturation
    rst_pulse();
    idle(22);
    rst_pulse();

    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, (mode == 2) ? 4 : 24) == 0) rst_pulse();
      else cycle(1'b0, ic_tab[$urandom_range(0, 7)], r_tab[$urandom_range(0, 4)],
                 r_tab[$urandom_range(0, 4)], ic_tab[$urandom_range(0, 7)],
                 r_tab[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                 ic_tab[$urandom_range(0, 7)], st_tab[$urandom_range(0, 5)],
                 ($urandom_range(0, 19) == 0) ? st_tab[$urandom_range(3, 5)]
                                              : st_tab[$urandom_range(0, 2)]);
    end

    @(negedge CLK);
    @(negedge CLK);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 pipeline.
- Each cycle it generates the stall/bubble controls for the F, D, E, M and W pipeline registers and the condition-code write enable.
- It handles load/use hazards, ret, mispredicted jXX and exceptions.
- It holds a small run-state machine that flushes the pipe after reset and freezes it on a terminal status, plus saturating hazard counters for performance analysis.

Parameters:
CNT_W, 32, width of each performance counter
AOK, 3'd1, status code: normal
HLT, 3'd2, status code: halt
ADR, 3'd3, status code: address error
INS, 3'd4, status code: invalid instruction

Ports:
CLK  input  1  pipeline clock, rising edge
RSTn  input  1  asynchronous active-low reset
D_icode  input  4  icode in decode register
d_srcA  input  4  decode-stage srcA (4'hF = none)
d_srcB  input  4  decode-stage srcB (4'hF = none)
E_icode  input  4  icode in execute register
E_dstM  input  4  execute-register dstM (4'hF = none)
e_Cnd  input  1  execute-stage condition result
M_icode  input  4  icode in memory register
m_stat  input  3  memory-stage computed status
W_stat  input  3  writeback-register status
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold decode register
D_bubble  output  1  load nop into decode register
E_bubble  output  1  load nop into execute register
M_bubble  output  1  load nop into memory register
W_stall  output  1  hold writeback register
set_cc  output  1  enable CC update
halted  output  1  pipeline frozen (registered)
final_stat  output  3  latched terminal status
cnt_cycles  output  CNT_W  RUN cycles
cnt_loaduse  output  CNT_W  load/use stall cycles
cnt_mispred  output  CNT_W  mispredict flush cycles
cnt_ret  output  CNT_W  ret bubble cycles

Behaviour:
- Opcodes: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B.
- exc(s) is true when s is HLT, ADR or INS. Status 0 (bubble) and AOK are non-terminal.
- Combinational terms:
  - lu = E_icode in {MRMOVQ, POPQ} && E_dstM != F && E_dstM in {d_srcA, d_srcB}
  - rt = RET in {D_icode, E_icode, M_icode}
  - mp = E_icode==JXX && !e_Cnd
- States: INIT, RUN, FROZEN (2-bit register).
- RSTn low, asynchronous:
  - state=INIT, halted=0, final_stat=AOK, all counters 0.
  - All control outputs follow INIT decoding.
- INIT: lasts exactly one cycle after RSTn rises.
  - Outputs: D_bubble=E_bubble=M_bubble=1; F_stall=D_stall=W_stall=set_cc=0.
  - Next state: RUN.
- RUN outputs (purely combinational, same cycle):
  - F_stall = lu || rt
  - D_stall = lu
  - D_bubble = mp || (!lu && rt)
  - E_bubble = mp || lu
  - M_bubble = exc(m_stat) || exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc = E_icode==OPQ && !exc(m_stat) && !exc(W_stat)
- RUN -> FROZEN: on a clock edge where exc(W_stat) is true.
  - final_stat <= W_stat, halted <= 1 (visible the cycle after detection).
- FROZEN outputs:
  - F_stall=D_stall=W_stall=1, M_bubble=1, D_bubble=E_bubble=0, set_cc=0.
  - Inputs are ignored. Leaves only via reset.
- Counters: update on clock edges in RUN only; each saturates at all-ones and never wraps.
  - cnt_cycles +1 every RUN cycle.
  - cnt_loaduse +1 when lu.
  - cnt_mispred +1 when mp.
  - cnt_ret +1 when (!lu && rt).
  - Multiple counters may increment in the same cycle.
- Simultaneous events:
  - lu && rt: stall D, bubble E, no D bubble.
  - mp && rt (ret in D or M with jXX in E): D_bubble=1, F_stall=1; cnt_mispred and cnt_ret both increment.
  - exc(W_stat) in the same cycle as any hazard: RUN decoding applies for that cycle, then FROZEN.
- Reset mid-operation: returns to INIT immediately; counters and final_stat cleared; no partial updates on the reset edge.

Test Plan:
- Reset then release -> INIT cycle with D/E/M_bubble=1, then RUN. All counters 0, final_stat=1, halted=0.
- E_icode=5, E_dstM=3, d_srcA=3 for one cycle -> F_stall=D_stall=E_bubble=1, D_bubble=0; cnt_loaduse=1 next cycle. With E_dstM=F -> no stall.
- D_icode=9, then E_icode=9, then M_icode=9 over 3 cycles -> F_stall=1 and D_bubble=1 each cycle; cnt_ret=3.
- E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0, cnt_mispred+1. Then E_icode=6, m_stat=3 -> set_cc=0, M_bubble=1.
- W_stat=2 in RUN -> W_stall=1 same cycle; next cycle halted=1, final_stat=2, all holds asserted. cnt_cycles frozen while W_stat returns to 1.
- Preload near-saturation by running 2^CNT_W cycles with CNT_W overridden to 4 -> cnt_cycles sticks at 15. Assert RSTn low mid-FROZEN -> all counters 0, halted=0 asynchronously.
